// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared pipeline constants used by the predictor and the branch resolver.
package branch_resolver_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic TAKEN = 1'b1;
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/branch_resolver_fifo.sv
// pred_fifo: in-flight prediction queue; clear wins over push/pop so a flush drops a same-cycle push.
module pred_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk_i) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end
    assign dout  = mem[rd_ptr];
    assign full  = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: compares resolved outcomes against queued predictions, feeds the
// predictor update and raises a flush with the correct fetch PC on a mispredict.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_i,
    input  logic            predict_i,
    input  logic [XLEN-1:0] target_i,
    input  logic [XLEN-1:0] fallthru_i,
    input  logic            resolve_i,
    input  logic            taken_i,
    output logic            update_o,
    output logic            result_o,
    output logic            flush_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            overflow_o,
    output logic [15:0]     mispredict_cnt_o
);
    localparam int W = 2 * XLEN + 1;
    logic [W-1:0] head;
    logic [$clog2(DEPTH):0] count;
    logic full, empty, accept, mispredict, push, head_pred;
    logic [XLEN-1:0] head_tgt, head_fth;
    assign {head_pred, head_tgt, head_fth} = head;
    assign accept     = resolve_i && count != '0;
    assign mispredict = accept && (taken_i != head_pred);
    // a resolve frees the head slot this cycle, so a full queue can still take an issue
    assign push       = issue_i && (!full || accept);
    assign full_o     = full;
    assign empty_o    = empty;

    pred_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (mispredict),
        .push  (push),
        .pop   (accept),
        .din   ({predict_i, target_i, fallthru_i}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            update_o         <= 1'b0;
            result_o         <= 1'b0;
            flush_o          <= 1'b0;
            redirect_pc_o    <= '0;
            overflow_o       <= 1'b0;
            mispredict_cnt_o <= '0;
        end else begin
            update_o <= accept;
            result_o <= accept && taken_i == TAKEN;
            flush_o  <= mispredict;
            if (mispredict) begin
                redirect_pc_o    <= (taken_i == TAKEN) ? head_tgt : head_fth;
                mispredict_cnt_o <= sat_inc16(mispredict_cnt_o);
            end
            if (issue_i && full && !accept) overflow_o <= 1'b1;
        end
    end
endmodule
